ama_riscv_fetch: RTL and testbench
==================================

# ama_riscv_fetch

Fetch datapath that executes `ama_riscv_fe_ctrl` decisions.
- Holds the PC and computes next-PC from `fe_ctrl.pc_sel` / `fe_ctrl.pc_we`.
- Drives the imem request address and tracks outstanding requests with their PCs.
- Discards stale responses after a redirect.
- Loads the IF/ID register (`pc_dec`, `inst_dec`) consumed by decode and by the stall controller.

## Interface
- `RESET_VEC`, default 32'h4000_0000: first fetch address. Must be nonzero, because `pc_exe == 0` means "invalid".
- `MAX_OUT`, default 2: maximum outstanding imem requests (power of 2, ≥ 1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fe_ctrl` in fe_ctrl_t: `pc_sel`, `pc_we`, `bubble_dec` from the stall controller.
- `alu_out` in arch_width_t: branch/jump target from execute.
- `hold_dec` in 1: decode stall (load hazard or dcache); freezes IF/ID.
- `imem_req_valid` in 1: request valid, driven by the stall controller and observed here.
- `imem_req_ready` in 1: imem accepts a request.
- `imem_req_addr` out arch_width_t: fetch address.
- `imem_rsp_valid` in 1: instruction returned.
- `imem_rsp_data` in 32: instruction word.
- `imem_rsp_ready` in 1: response accepted, driven by the stall controller.
- `pc_dec` out arch_width_t: PC of the instruction in decode.
- `inst_dec` out 32: instruction in decode.
- `inst_valid_dec` out 1: decode slot holds a real instruction.
- `outstanding` out $clog2(MAX_OUT)+1: in-flight request count.

## Operation
- **PC register.** Updates only when `pc_we` = 1.
  - PC_SEL_INC4 → pc+4.
  - PC_SEL_ALU → `{alu_out[31:1],1'b0}` (bit 0 cleared, as for jalr).
  - PC_SEL_PC → pc unchanged.
  - Any other encoding → pc unchanged.
  - Arithmetic wraps modulo 2^32; 32'hFFFF_FFFC+4 = 0.
- **Request address.** `imem_req_addr` = pc, combinational.
- **Handshakes.** req_fire = `imem_req_valid & imem_req_ready`. rsp_fire = `imem_rsp_valid & imem_rsp_ready`.
- **Address FIFO.** Sub-module, depth MAX_OUT. Push pc on req_fire; pop on rsp_fire. The popped entry is the PC of the returned instruction.
- **Outstanding counter.**
  - +1 on req_fire alone, −1 on rsp_fire alone, unchanged when both fire.
  - req_fire at MAX_OUT, or rsp_fire at 0, is a protocol error. The assertion must fire; the counter saturates.
- **Redirect.** A redirect is `pc_we & pc_sel==PC_SEL_ALU`.
  - drop_cnt ← outstanding − rsp_fire (this cycle).
  - While drop_cnt > 0, each rsp_fire pops the FIFO, decrements drop_cnt, and does not touch IF/ID.
  - A second redirect overwrites drop_cnt with the same formula.
- **Skid register.** One entry.
  - A non-dropped rsp_fire while `hold_dec` = 1 is stored in skid as {pc, inst}.
  - rsp_fire while skid is already full is a protocol error (assert).
- **IF/ID update priority** (per cycle):
  1. `hold_dec`: IF/ID keeps its value.
  2. Skid full: IF/ID ← skid; skid empties. A simultaneous non-dropped rsp_fire goes into skid.
  3. Non-dropped rsp_fire: IF/ID ← {fifo_pc, data}; `inst_valid_dec` = 1.
  4. `bubble_dec`: `inst_dec` ← NOP 32'h0000_0013; `inst_valid_dec` = 0; `pc_dec` held.
  5. Otherwise: IF/ID holds.

## Timing
- **Reset values:** pc = RESET_VEC; `pc_dec` = 0; `inst_dec` = NOP; `inst_valid_dec` = 0; `outstanding` = 0; drop_cnt = 0; skid empty; FIFO empty.
- **Reset mid-operation:** asynchronous. All state returns to reset values immediately; in-flight responses after reset release are unaccounted and must not arrive (imem is reset by the same `rst`).
- **Latencies:**
  - rsp_fire in cycle N → `inst_dec`/`pc_dec` valid in N+1.
  - `pc_we` in N → new `imem_req_addr` in N+1.
  - Redirect in N → responses from N+1 on are dropped until drop_cnt = 0.
- **Zero-outstanding redirect:** drop_cnt = 0; the first response after the redirect is used.

## Structure
- Shared package/defines: fe_ctrl_t, pc_sel enum (PC_SEL_PC, PC_SEL_INC4, PC_SEL_ALU), arch_width_t, `INST_NOP` constant, FE_CTRL reset value.
- Sub-module `ama_riscv_fetch_addr_fifo`:
  - Parameter DEPTH.
  - Push/pop, with simultaneous push+pop allowed.
  - Full/empty outputs.
  - Pointers wrap modulo DEPTH.

## Test plan
- **Reset and first fetch.** Release `rst`, ready=1, `imem_req_valid`=1 → `imem_req_addr` = 32'h4000_0000. rsp 32'h0000_0093 next cycle → `inst_dec` = 0x93, `pc_dec` = 0x4000_0000, `inst_valid_dec` = 1.
- **Sequential stream.** INC4 with `pc_we` every cycle for 4 fetches → addresses 0x…00/04/08/0C; `pc_dec` tracks them one cycle after each response.
- **Redirect with 2 outstanding.** pc_sel=ALU, `alu_out` = 0x4000_0101 → next addr 0x4000_0100. The next two responses are dropped (`inst_valid_dec` stays 0); the third lands with `pc_dec` = 0x4000_0100.
- **Hold collision.** `hold_dec`=1 while rsp 0xDEAD_BEEF fires → IF/ID unchanged. Release hold → `inst_dec` = 0xDEAD_BEEF one cycle later.
- **Bubble.** `bubble_dec`=1, no rsp → `inst_dec` = 0x13, `inst_valid_dec` = 0, `pc_dec` unchanged.
- **Wrap and reset.** PC 0xFFFF_FFFC, INC4 → 0x0. Assert `rst` mid-stream with outstanding=2 → `outstanding` = 0, pc = RESET_VEC the same cycle.

Source files
------------

// File: rtl/ama_riscv_fetch_pkg.sv
// Shared types and constants for the fetch datapath.
// Provides the architectural word type, the PC-select encoding, the
// fe_ctrl bundle coming from the stall controller, the NOP encoding
// and the next-PC helper.
package ama_riscv_fetch_pkg;

  localparam int ARCH_WIDTH = 32;

  typedef logic [ARCH_WIDTH-1:0] arch_width_t;

  typedef enum logic [1:0] {
    PC_SEL_PC   = 2'd0,
    PC_SEL_INC4 = 2'd1,
    PC_SEL_ALU  = 2'd2
  } pc_sel_t;

  typedef struct packed {
    pc_sel_t pc_sel;
    logic    pc_we;
    logic    bubble_dec;
  } fe_ctrl_t;

  localparam fe_ctrl_t FE_CTRL_RST = '{pc_sel: PC_SEL_PC, pc_we: 1'b0, bubble_dec: 1'b0};

  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Unused encodings keep the PC where it is. ALU targets have bit 0
  // cleared, matching jalr semantics.
  function automatic arch_width_t pc_next(input arch_width_t pc,
                                          input pc_sel_t     sel,
                                          input arch_width_t alu_out);
    arch_width_t nxt;
    case (sel)
      PC_SEL_INC4: nxt = pc + 32'd4;
      PC_SEL_ALU:  nxt = {alu_out[31:1], 1'b0};
      default:     nxt = pc;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ama_riscv_fetch_if.sv
// Instruction memory request/response bundle.
// master: fetch side (drives the request address, observes the rest).
// slave:  imem side (drives req_ready and the response).
// imem_req_valid and imem_rsp_ready come from the stall controller; both
// sides only observe them.
interface ama_riscv_fetch_if;
  import ama_riscv_fetch_pkg::*;

  logic        imem_req_valid;
  logic        imem_req_ready;
  arch_width_t imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_ready;

  modport master (
    input  imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  imem_rsp_ready
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  imem_rsp_ready
  );

endinterface

// File: rtl/ama_riscv_fetch_addr_fifo.sv
// Small FIFO holding the PCs of in-flight imem requests.
// Ports: clk, rst (async, active high), push/push_data, pop/pop_data
// (head entry, combinational), full, empty.
// Simultaneous push and pop are allowed, including when full. A push
// into a full FIFO without a pop, or a pop from empty, is ignored.
module ama_riscv_fetch_addr_fifo
  import ama_riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  arch_width_t push_data,
  input  logic        pop,
  output arch_width_t pop_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  arch_width_t     mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= ptr_inc(wptr);
      if (do_pop)  rptr <= ptr_inc(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ama_riscv_fetch.sv
// Fetch datapath: executes fe_ctrl decisions from the stall controller.
// Ports: clk, rst (async, active high); fe_ctrl (pc_sel/pc_we/bubble_dec);
// alu_out (redirect target); hold_dec (freezes IF/ID); imem (request /
// response bundle, master side); pc_dec/inst_dec/inst_valid_dec (IF/ID);
// outstanding (in-flight request count).
// Responses that were requested before a redirect are counted in drop_cnt
// and discarded as they arrive. A response that arrives while decode is
// held lands in a one-entry skid register and is released when hold drops.
module ama_riscv_fetch
  import ama_riscv_fetch_pkg::*;
#(
  parameter arch_width_t RESET_VEC = 32'h4000_0000,
  parameter int          MAX_OUT   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  fe_ctrl_t                 fe_ctrl,
  input  arch_width_t              alu_out,
  input  logic                     hold_dec,
  ama_riscv_fetch_if.master        imem,
  output arch_width_t              pc_dec,
  output logic [31:0]              inst_dec,
  output logic                     inst_valid_dec,
  output logic [$clog2(MAX_OUT):0] outstanding
);

  localparam int              CNT_W   = $clog2(MAX_OUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  arch_width_t      pc;
  logic             req_fire;
  logic             rsp_fire;
  logic             redirect;
  logic             drop_active;
  logic             rsp_use;
  logic [CNT_W-1:0] drop_cnt;
  arch_width_t      fifo_pc;
  logic             fifo_full;
  logic             fifo_empty;
  logic             skid_full;
  arch_width_t      skid_pc;
  logic [31:0]      skid_inst;

  assign imem.imem_req_addr = pc;
  assign req_fire    = imem.imem_req_valid & imem.imem_req_ready;
  assign rsp_fire    = imem.imem_rsp_valid & imem.imem_rsp_ready;
  assign redirect    = fe_ctrl.pc_we & (fe_ctrl.pc_sel == PC_SEL_ALU);
  assign drop_active = (drop_cnt != '0);
  assign rsp_use     = rsp_fire & ~drop_active;

  ama_riscv_fetch_addr_fifo #(
    .DEPTH (MAX_OUT)
  ) u_addr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (pc),
    .pop       (rsp_fire),
    .pop_data  (fifo_pc),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_VEC;
    end else if (fe_ctrl.pc_we) begin
      pc <= pc_next(pc, fe_ctrl.pc_sel, alu_out);
    end
  end

  // Saturates on protocol errors instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else if (req_fire && !rsp_fire && outstanding != CNT_MAX) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (rsp_fire && !req_fire && outstanding != '0) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

  // Everything still in flight after this cycle's response belongs to the
  // old path. A request fired in the redirect cycle itself is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (redirect) begin
      drop_cnt <= (rsp_fire && outstanding != '0) ? outstanding - CNT_W'(1) : outstanding;
    end else if (rsp_fire && drop_active) begin
      drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_dec         <= '0;
      inst_dec       <= INST_NOP;
      inst_valid_dec <= 1'b0;
      skid_full      <= 1'b0;
      skid_pc        <= '0;
      skid_inst      <= '0;
    end else if (hold_dec) begin
      if (rsp_use) begin
        skid_full <= 1'b1;
        skid_pc   <= fifo_pc;
        skid_inst <= imem.imem_rsp_data;
      end
    end else if (skid_full) begin
      pc_dec         <= skid_pc;
      inst_dec       <= skid_inst;
      inst_valid_dec <= 1'b1;
      if (rsp_use) begin
        skid_pc   <= fifo_pc;
        skid_inst <= imem.imem_rsp_data;
      end else begin
        skid_full <= 1'b0;
      end
    end else if (rsp_use) begin
      pc_dec         <= fifo_pc;
      inst_dec       <= imem.imem_rsp_data;
      inst_valid_dec <= 1'b1;
    end else if (fe_ctrl.bubble_dec) begin
      inst_dec       <= INST_NOP;
      inst_valid_dec <= 1'b0;
    end
  end

  a_req_overflow: assert property (@(posedge clk) disable iff (rst)
    !(req_fire && !rsp_fire && (outstanding == CNT_MAX || fifo_full)));

  a_rsp_underflow: assert property (@(posedge clk) disable iff (rst)
    !(rsp_fire && (outstanding == '0 || fifo_empty)));

  a_skid_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rsp_use && skid_full && hold_dec));

endmodule

// File: tb/tb_ama_riscv_fetch.sv
module tb_ama_riscv_fetch;
  import ama_riscv_fetch_pkg::*;

  localparam arch_width_t RESET_VEC = 32'h4000_0000;
  localparam int          MAX_OUT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  fe_ctrl_t    fe_ctrl;
  arch_width_t alu_out;
  logic        hold_dec;
  arch_width_t pc_dec;
  logic [31:0] inst_dec;
  logic        inst_valid_dec;
  logic [1:0]  outstanding;

  ama_riscv_fetch_if imem_if ();

  ama_riscv_fetch #(
    .RESET_VEC (RESET_VEC),
    .MAX_OUT   (MAX_OUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fe_ctrl        (fe_ctrl),
    .alu_out        (alu_out),
    .hold_dec       (hold_dec),
    .imem           (imem_if),
    .pc_dec         (pc_dec),
    .inst_dec       (inst_dec),
    .inst_valid_dec (inst_valid_dec),
    .outstanding    (outstanding)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: in-flight requests kept as a queue of PCs, each
  // tagged stale when a redirect happens while it is still in flight.
  arch_width_t m_pc;
  arch_width_t m_q_pc[$];
  bit          m_q_stale[$];
  arch_width_t m_pc_dec;
  logic [31:0] m_inst;
  bit          m_valid;
  bit          m_skid_full;
  arch_width_t m_skid_pc;
  logic [31:0] m_skid_inst;

  task automatic model_reset();
    m_pc = RESET_VEC;
    m_q_pc.delete();
    m_q_stale.delete();
    m_pc_dec = '0;
    m_inst = 32'h0000_0013;
    m_valid = 0;
    m_skid_full = 0;
    m_skid_pc = '0;
    m_skid_inst = '0;
  endtask

  task automatic model_step();
    bit          req_f;
    bit          rsp_f;
    bit          use_rsp;
    arch_width_t rpc;
    logic [31:0] rdata;
    req_f   = imem_if.imem_req_valid && imem_if.imem_req_ready;
    rsp_f   = imem_if.imem_rsp_valid && imem_if.imem_rsp_ready;
    rdata   = imem_if.imem_rsp_data;
    use_rsp = 0;
    rpc     = '0;
    if (rsp_f && m_q_pc.size() > 0) begin
      rpc     = m_q_pc.pop_front();
      use_rsp = !m_q_stale.pop_front();
    end
    if (fe_ctrl.pc_we && fe_ctrl.pc_sel == PC_SEL_ALU)
      foreach (m_q_stale[i]) m_q_stale[i] = 1;
    if (req_f) begin
      m_q_pc.push_back(m_pc);
      m_q_stale.push_back(0);
    end
    if (hold_dec) begin
      if (use_rsp) begin
        m_skid_full = 1; m_skid_pc = rpc; m_skid_inst = rdata;
      end
    end else if (m_skid_full) begin
      m_pc_dec = m_skid_pc; m_inst = m_skid_inst; m_valid = 1;
      m_skid_full = use_rsp;
      if (use_rsp) begin m_skid_pc = rpc; m_skid_inst = rdata; end
    end else if (use_rsp) begin
      m_pc_dec = rpc; m_inst = rdata; m_valid = 1;
    end else if (fe_ctrl.bubble_dec) begin
      m_inst = 32'h0000_0013; m_valid = 0;
    end
    if (fe_ctrl.pc_we) begin
      if (fe_ctrl.pc_sel == PC_SEL_INC4)     m_pc = m_pc + 32'd4;
      else if (fe_ctrl.pc_sel == PC_SEL_ALU) m_pc = alu_out & 32'hFFFF_FFFE;
    end
  endtask

  task automatic compare();
    chk("req_addr", imem_if.imem_req_addr, m_pc);
    chk("pc_dec", pc_dec, m_pc_dec);
    chk("inst_dec", inst_dec, m_inst);
    chk("inst_valid_dec", {31'd0, inst_valid_dec}, {31'd0, m_valid});
    chk("outstanding", {30'd0, outstanding}, m_q_pc.size());
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle();
    fe_ctrl                = FE_CTRL_RST;
    alu_out                = '0;
    hold_dec               = 1'b0;
    imem_if.imem_req_valid = 1'b0;
    imem_if.imem_req_ready = 1'b1;
    imem_if.imem_rsp_valid = 1'b0;
    imem_if.imem_rsp_ready = 1'b1;
    imem_if.imem_rsp_data  = '0;
  endtask

  task automatic fetch_inc4();
    fe_ctrl.pc_sel         = PC_SEL_INC4;
    fe_ctrl.pc_we          = 1'b1;
    imem_if.imem_req_valid = 1'b1;
  endtask

  task automatic respond(input logic [31:0] data);
    imem_if.imem_rsp_valid = 1'b1;
    imem_if.imem_rsp_data  = data;
  endtask

  initial begin
    arch_width_t saved_pc;
    logic [31:0] saved_inst;
    logic [1:0]  sel;
    int          r;

    idle();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compare();
    chk("rst_inst_nop", inst_dec, 32'h0000_0013);
    chk("rst_addr", imem_if.imem_req_addr, RESET_VEC);
    rst = 1'b0;

    // reset and first fetch
    idle(); fetch_inc4();
    chk("first_addr", imem_if.imem_req_addr, 32'h4000_0000);
    step();
    idle(); respond(32'h0000_0093);
    step();
    chk("first_inst", inst_dec, 32'h0000_0093);
    chk("first_pc_dec", pc_dec, 32'h4000_0000);
    chk("first_valid", {31'd0, inst_valid_dec}, 32'd1);

    // sequential stream, response one cycle after each request
    for (int k = 0; k < 5; k++) begin
      idle();
      if (k < 4) begin
        fetch_inc4();
        chk("seq_addr", imem_if.imem_req_addr, 32'h4000_0004 + 32'(4 * k));
      end
      if (k > 0) respond(32'h1000_0000 + 32'(k));
      step();
      if (k > 0) chk("seq_pc_dec", pc_dec, 32'h4000_0004 + 32'(4 * (k - 1)));
    end

    // redirect with two outstanding
    for (int k = 0; k < 2; k++) begin
      idle(); fetch_inc4(); fe_ctrl.bubble_dec = 1'b1;
      step();
    end
    chk("redir_out_before", {30'd0, outstanding}, 32'd2);
    idle();
    fe_ctrl.pc_sel = PC_SEL_ALU; fe_ctrl.pc_we = 1'b1; alu_out = 32'h4000_0101;
    step();
    chk("redir_addr", imem_if.imem_req_addr, 32'h4000_0100);
    idle(); fetch_inc4(); respond(32'hAAAA_0001);
    step();
    chk("redir_drop1", {31'd0, inst_valid_dec}, 32'd0);
    idle(); respond(32'hAAAA_0002);
    step();
    chk("redir_drop2", {31'd0, inst_valid_dec}, 32'd0);
    idle(); respond(32'h1111_2222);
    step();
    chk("redir_land_pc", pc_dec, 32'h4000_0100);
    chk("redir_land_valid", {31'd0, inst_valid_dec}, 32'd1);

    // hold collision
    idle(); fetch_inc4();
    step();
    saved_pc = pc_dec; saved_inst = inst_dec;
    idle(); hold_dec = 1'b1; respond(32'hDEAD_BEEF);
    step();
    chk("hold_inst", inst_dec, saved_inst);
    chk("hold_pc", pc_dec, saved_pc);
    idle();
    step();
    chk("hold_release_inst", inst_dec, 32'hDEAD_BEEF);
    chk("hold_release_pc", pc_dec, 32'h4000_0104);

    // bubble
    saved_pc = pc_dec;
    idle(); fe_ctrl.bubble_dec = 1'b1;
    step();
    chk("bubble_inst", inst_dec, 32'h0000_0013);
    chk("bubble_valid", {31'd0, inst_valid_dec}, 32'd0);
    chk("bubble_pc", pc_dec, saved_pc);

    // wrap and async reset with two outstanding
    idle();
    fe_ctrl.pc_sel = PC_SEL_ALU; fe_ctrl.pc_we = 1'b1; alu_out = 32'hFFFF_FFFC;
    step();
    chk("wrap_top", imem_if.imem_req_addr, 32'hFFFF_FFFC);
    idle(); fetch_inc4();
    step();
    chk("wrap_zero", imem_if.imem_req_addr, 32'h0000_0000);
    idle(); fetch_inc4();
    step();
    chk("wrap_out2", {30'd0, outstanding}, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", {30'd0, outstanding}, 32'd0);
    chk("async_rst_addr", imem_if.imem_req_addr, RESET_VEC);
    model_reset();
    @(posedge clk);
    #1;
    idle();
    rst = 1'b0;
    compare();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      idle();
      r = $urandom_range(0, 9);
      if (r < 6)      sel = 2'd1;
      else if (r < 8) sel = 2'd0;
      else if (r < 9) sel = 2'd2;
      else            sel = 2'd3;
      fe_ctrl.pc_sel     = pc_sel_t'(sel);
      fe_ctrl.pc_we      = ($urandom_range(0, 3) != 0);
      fe_ctrl.bubble_dec = ($urandom_range(0, 4) == 0);
      alu_out            = $urandom;
      hold_dec           = ($urandom_range(0, 3) == 0);
      imem_if.imem_req_valid = (m_q_pc.size() < MAX_OUT) && ($urandom_range(0, 1) == 1);
      imem_if.imem_req_ready = ($urandom_range(0, 3) != 0);
      imem_if.imem_rsp_valid = (m_q_pc.size() > 0) && !(m_skid_full && hold_dec)
                               && ($urandom_range(0, 2) != 0);
      imem_if.imem_rsp_ready = ($urandom_range(0, 3) != 0);
      imem_if.imem_rsp_data  = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
